// File: rtl/dw_window_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dw_window_sched_pkg
// Brief   : Shared defaults, tap indexing and FSM encoding for the 3x3
//           depthwise-conv window scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package dw_window_sched_pkg;

    localparam int c_ACT_W_DEF = 16;
    localparam int c_CH_DEF    = 8;

    // Position of tap (ky,kx) inside one channel's 9-tap group.
    function automatic int tap_idx(input int ky, input int kx);
        return ky * 3 + kx;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dw_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dw_line_buffer
// Brief   : Two-row line store. Each write at column addr pushes the newest
//           row's pixel down to the older row, so a read always returns the
//           two rows above the pixel currently being scanned.
// Revision: 1.0 - initial release
// ============================================================================
module dw_line_buffer #(
    parameter int IMG_W = 8,
    parameter int DW    = 128
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           we,
    input  logic [$clog2(IMG_W+1)-1:0]     addr,
    input  logic [DW-1:0]                  wdata,
    output logic [DW-1:0]                  rd_old,
    output logic [DW-1:0]                  rd_new
);

    localparam int c_AW = $clog2(IMG_W + 1);
    localparam int c_IW = $clog2(IMG_W);
    localparam logic [c_AW-1:0] c_W = c_AW'(IMG_W);

    logic [DW-1:0] r_old [IMG_W];
    logic [DW-1:0] r_new [IMG_W];
    logic          w_hit;

    // Padding column (addr == IMG_W) has no storage and reads as zero.
    assign w_hit  = (addr < c_W);
    assign rd_old = w_hit ? r_old[addr[c_IW-1:0]] : '0;
    assign rd_new = w_hit ? r_new[addr[c_IW-1:0]] : '0;

    // Column-wise shift: newest row ages into the older row on each write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_old[i] <= '0;
                r_new[i] <= '0;
            end
        end else if (we && w_hit) begin
            r_old[addr[c_IW-1:0]] <= r_new[addr[c_IW-1:0]];
            r_new[addr[c_IW-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dw_window_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dw_window_sched
// Brief   : Walks a padded (IMG_H+1)x(IMG_W+1) grid over a raster pixel
//           stream and emits zero-padded 3x3 windows for the depthwise
//           datapath, with stride 1 or 2 and ready/valid on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module dw_window_sched
    import dw_window_sched_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int CH     = c_CH_DEF,
    parameter int ACT_W  = c_ACT_W_DEF,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [CH*ACT_W-1:0]   in_data,
    output logic                  in_ready,
    output logic                  win_valid,
    output logic [CH*9*ACT_W-1:0] win_data,
    input  logic                  win_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_RW = $clog2(IMG_H + 1);
    localparam int c_CW = $clog2(IMG_W + 1);
    localparam int c_PW = CH * ACT_W;
    localparam int c_WW = CH * 9 * ACT_W;
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W);
    localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);
    localparam logic [c_CW-1:0] c_COL_ONE  = c_CW'(1);

    state_t            r_state;
    logic              r_busy;
    logic              r_frame_done;
    logic [c_RW-1:0]   r_row;
    logic [c_CW-1:0]   r_col;
    logic [c_PW-1:0]   r_c1 [0:2];
    logic [c_PW-1:0]   r_c2 [0:2];
    logic              r_win_valid;
    logic [c_WW-1:0]   r_win_data;

    logic              w_real;
    logic              w_col_real;
    logic              w_row_last;
    logic              w_col_last;
    logic              w_adv;
    logic              w_emit;
    logic              w_start_go;
    logic [c_PW-1:0]   w_pix;
    logic [c_PW-1:0]   w_new [0:2];
    logic [c_PW-1:0]   w_lb_old;
    logic [c_PW-1:0]   w_lb_new;
    logic [c_WW-1:0]   w_win;
    logic [ACT_W-1:0]  w_tap;

    assign w_row_last = (r_row == c_ROW_LAST);
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_col_real = (r_col < c_COL_LAST);
    assign w_real     = (r_row < c_ROW_LAST) && w_col_real;
    assign w_start_go = (r_state == ST_IDLE) && start;
    assign w_adv      = (r_state == ST_RUN) && (!r_win_valid || win_ready) &&
                        (!w_real || in_valid);
    // Odd padded coordinates are exactly those with (coord-1) divisible by 2.
    assign w_emit     = (r_row != '0) && (r_col != '0) &&
                        ((STRIDE == 1) || r_row[0]) && ((STRIDE == 1) || r_col[0]);
    assign w_pix      = w_real ? in_data : '0;

    assign in_ready   = (r_state == ST_RUN) && w_real && (!r_win_valid || win_ready);
    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    dw_line_buffer #(
        .IMG_W (IMG_W),
        .DW    (c_PW)
    ) u_lb (
        .clk    (clk),
        .rstn   (rstn),
        .we     (w_adv),
        .addr   (r_col),
        .wdata  (w_pix),
        .rd_old (w_lb_old),
        .rd_new (w_lb_new)
    );

    // Incoming column, top to bottom: two buffered rows then the scanned pixel.
    always_comb begin
        w_new[0] = w_lb_old;
        w_new[1] = w_lb_new;
        w_new[2] = w_pix;
    end

    // Assemble the window; top row / left column are masked at the image
    // edge, which also stops stale columns wrapping in from the previous row.
    always_comb begin
        w_win = '0;
        w_tap = '0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    if (kx == 0)      w_tap = r_c1[ky][ch*ACT_W +: ACT_W];
                    else if (kx == 1) w_tap = r_c2[ky][ch*ACT_W +: ACT_W];
                    else              w_tap = w_new[ky][ch*ACT_W +: ACT_W];
                    if ((ky == 0 && r_row == c_ROW_ONE) || (kx == 0 && r_col == c_COL_ONE))
                        w_tap = '0;
                    w_win[ch*9*ACT_W + tap_idx(ky, kx)*ACT_W +: ACT_W] = w_tap;
                end
            end
        end
    end

    // Frame control FSM with registered busy / frame_done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
                ST_RUN: if (w_adv && w_row_last && w_col_last) r_state <= ST_DRAIN;
                ST_DRAIN: if (!r_win_valid || win_ready) begin
                    r_state      <= ST_DONE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Raster scan over the padded grid, one position per advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start_go) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_adv) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Keep the two most recent columns for the left and centre taps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                r_c1[k] <= '0;
                r_c2[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < 3; k++) begin
                r_c1[k] <= r_c2[k];
                r_c2[k] <= w_new[k];
            end
        end
    end

    // Output window register; reload may coincide with a handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
        end else if (w_adv && w_emit) begin
            r_win_valid <= 1'b1;
            r_win_data  <= w_win;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
